// File: rtl/inv_key_schedule.sv
// Inverse AES-256 key schedule: walks the expanded key backwards one word per cycle and
// streams round keys numRounds..0 over valid/ready. Optional KEY_MATCH_EN adds refKey/keyMatch.
module inv_ks_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int n = 0; n < 8; n++) begin
      if (y[n]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // GF(2^8) inverse as a^254 (maps 0 to 0), then the AES affine transform
  always_comb begin
    logic [7:0] p;
    p   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_key_schedule #(
  parameter int numkeys   = 8,
  parameter int numRounds = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [0:32*numkeys-1]   lastKey,
`ifdef KEY_MATCH_EN
  input  logic [0:32*numkeys-1]   refKey,
  output logic                    keyMatch,
`endif
  output logic [0:127]            roundKey,
  output logic [3:0]              roundIdx,
  output logic                    keyValid,
  input  logic                    keyReady,
  output logic                    busy,
  output logic                    done
);
  localparam int NK = numkeys;

  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO, CALC} state_t;
  state_t state, state_nx;

  logic [31:0] win [NK];
  logic [5:0]  j;
  logic [3:0]  idx;
  logic [1:0]  step;
  logic [5:0]  i, imod, idiv;
  logic [7:0]  rcon;
  logic [31:0] sub_in, sub_out, fx, nw;

  assign i    = j + 6'(NK - 1);
  assign imod = i % 6'(NK);
  assign idiv = i / 6'(NK);
  assign rcon = 8'h01 << (idiv - 6'd1);

  always_comb begin
    sub_in = (imod == 6'd0) ? {win[NK-2][23:0], win[NK-2][31:24]} : win[NK-2];
    fx     = win[NK-2];
    if (imod == 6'd0)
      fx = sub_out ^ {rcon, 24'h0};
    else if (NK > 6 && imod == 6'd4)
      fx = sub_out;
    nw = win[NK-1] ^ fx;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    inv_ks_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
  end

  assign keyValid = (state == EMIT_HI) || (state == EMIT_LO);
  assign busy     = (state != IDLE);
  assign roundIdx = idx;

  always_comb begin
    roundKey = '0;
    if (state == EMIT_HI)      roundKey = {win[4], win[5], win[6], win[7]};
    else if (state == EMIT_LO) roundKey = {win[0], win[1], win[2], win[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EMIT_HI;
      EMIT_HI: if (keyReady) state_nx = EMIT_LO;
      EMIT_LO: if (keyReady) state_nx = (idx == 4'd0) ? IDLE : CALC;
      CALC:    if (step == 2'd3) state_nx = EMIT_LO;
      default: state_nx = IDLE;
    endcase
  end

`ifdef KEY_MATCH_EN
  logic [0:32*NK-1] winflat;
  always_comb begin
    winflat = '0;
    for (int k = 0; k < NK; k++) winflat[32*k +: 32] = win[k];
  end
`endif

  // idx is decremented on each accept, so it already names the round being computed in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) win[k] <= '0;
      j    <= '0;
      idx  <= '0;
      step <= '0;
      done <= 1'b0;
`ifdef KEY_MATCH_EN
      keyMatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < NK; k++) win[k] <= lastKey[32*k +: 32];
          j   <= 6'(4*(numRounds+1) - NK);
          idx <= 4'(numRounds);
`ifdef KEY_MATCH_EN
          keyMatch <= 1'b0;
`endif
        end
        EMIT_HI: if (keyReady) idx <= idx - 4'd1;
        EMIT_LO: if (keyReady) begin
          step <= '0;
          if (idx == 4'd0) begin
            done <= 1'b1;
`ifdef KEY_MATCH_EN
            keyMatch <= (winflat == refKey);
`endif
          end else begin
            idx <= idx - 4'd1;
          end
        end
        CALC: begin
          win[0] <= nw;
          for (int k = 1; k < NK; k++) win[k] <= win[k-1];
          j    <= j - 6'd1;
          step <= step + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
